// File: rtl/dds_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dds_ctrl_pkg
//   Shared constants for the DDS serial-write scheduler:
//     - 3-bit scheduler state encoding (IDLE/ISSUE/WAIT/UPDATE/DONE)
//     - ISSUE-phase timeout (cycles to wait for the writer to go busy)
//     - default byte-count width and maximum write length
//     - wrap_inc(): index increment modulo n, used for the round-robin pointer
// ----------------------------------------------------------------------------
package dds_ctrl_pkg;

  // Scheduler states. Kept as plain constants so the encoding is visible
  // in waveforms and matches older tooling that decodes the raw bits.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Cycles wr_ready may stay up without the writer going busy before the
  // scheduler gives up on the transaction.
  localparam int ISSUE_TIMEOUT = 8;
  localparam int ISSUE_CNT_W   = $clog2(ISSUE_TIMEOUT);

  // Default writer geometry: byte count field width and max bytes per write.
  localparam int LENGTH_BIT_COUNT_DEF = 3;
  localparam int MAXLENGTH_DEF        = (1 << LENGTH_BIT_COUNT_DEF) - 1;

  // Increment idx, wrapping to 0 at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dds_spi_write_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick: the first asserted request at or
//   after ptr, searching upward and wrapping. The pointer register itself
//   lives in the parent so the parent decides when a grant is committed.
//
// Ports
//   req        in   NUM_REQ   request vector
//   ptr        in   IDX_W     highest-priority index for this pick
//   grant      out  NUM_REQ   one-hot winner (all zero when no request)
//   grant_idx  out  IDX_W     encoded winner index
//   valid      out  1         at least one request is asserted
// ----------------------------------------------------------------------------
module rr_arbiter
  import dds_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               valid
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      // First hit in search order wins; later hits are ignored.
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dds_spi_write_scheduler.sv
// ----------------------------------------------------------------------------
// dds_spi_write_scheduler
//   Shares one DDS serial register writer among NUM_REQ requesters with
//   round-robin arbitration and a single transaction in flight. For each
//   grant it presents bytes/data to the writer, raises wr_ready until the
//   writer reports busy, waits for the writer to finish, optionally strobes
//   io_update, then pulses done (and err on rejection) for the winner.
//   All logic runs on the posedge of SPI_clk; the writer runs on negedge.
//
// Configuration
//   DDS_IO_UPDATE_EN  defined: io_update is held high IOUPD_CYCLES cycles
//                     after every successful write (UPDATE state).
//                     undefined: no UPDATE state, io_update tied low.
//
// Ports
//   SPI_clk     in   1                  clock
//   reset_n     in   1                  async active-low reset
//   req         in   NUM_REQ            level requests, held until done
//   req_bytes   in   NUM_REQ*LBC        per-requester byte count, flat
//   req_data    in   NUM_REQ*MAXLENGTH8 per-requester MSB-first payload, flat
//   done        out  NUM_REQ            one-cycle completion pulse
//   err         out  NUM_REQ            one-cycle pulse with done on reject/stall
//   sched_busy  out  1                  high from grant until the done pulse
//   wr_bytes    out  LBC                writer byte count
//   wr_data     out  MAXLENGTH8         writer payload
//   wr_ready    out  1                  writer start handshake
//   wr_busy     in   1                  writer busy
//   io_update   out  1                  DDS IO_UPDATE strobe
// ----------------------------------------------------------------------------
module dds_spi_write_scheduler
  import dds_ctrl_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int LENGTH_BIT_COUNT = LENGTH_BIT_COUNT_DEF,
  parameter int MAXLENGTH        = MAXLENGTH_DEF,
  parameter int MAXLENGTH8       = MAXLENGTH * 8,
  parameter int IOUPD_CYCLES     = 4
) (
  input  logic                              SPI_clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*LENGTH_BIT_COUNT-1:0] req_bytes,
  input  logic [NUM_REQ*MAXLENGTH8-1:0]     req_data,
  output logic [NUM_REQ-1:0]                done,
  output logic [NUM_REQ-1:0]                err,
  output logic                              sched_busy,
  output logic [LENGTH_BIT_COUNT-1:0]       wr_bytes,
  output logic [MAXLENGTH8-1:0]             wr_data,
  output logic                              wr_ready,
  input  logic                              wr_busy,
  output logic                              io_update
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Elaboration-time guard against inconsistent writer geometry.
  if (NUM_REQ < 2 || MAXLENGTH != (1 << LENGTH_BIT_COUNT) - 1 ||
      MAXLENGTH8 != MAXLENGTH * 8 || IOUPD_CYCLES < 1 || IOUPD_CYCLES > 255)
  begin : g_param_check
    $error("dds_spi_write_scheduler: inconsistent parameters");
  end

  logic [2:0]             state;
  logic [IDX_W-1:0]       ptr;
  logic [NUM_REQ-1:0]     winner;
  logic [ISSUE_CNT_W-1:0] issue_cnt;

  logic [NUM_REQ-1:0]          arb_grant;
  logic [IDX_W-1:0]            arb_idx;
  logic                        arb_valid;
  logic [LENGTH_BIT_COUNT-1:0] win_bytes;
  logic [MAXLENGTH8-1:0]       win_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  // One-hot select of the winner's byte count and payload.
  always_comb begin
    win_bytes = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        win_bytes = req_bytes[i*LENGTH_BIT_COUNT +: LENGTH_BIT_COUNT];
        win_data  = req_data[i*MAXLENGTH8 +: MAXLENGTH8];
      end
    end
  end

`ifdef DDS_IO_UPDATE_EN
  logic [7:0] upd_cnt;
`else
  assign io_update = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge SPI_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      winner     <= '0;
      issue_cnt  <= '0;
      done       <= '0;
      err        <= '0;
      sched_busy <= 1'b0;
      wr_bytes   <= '0;
      wr_data    <= '0;
      wr_ready   <= 1'b0;
`ifdef DDS_IO_UPDATE_EN
      upd_cnt    <= '0;
      io_update  <= 1'b0;
`endif
    end else begin
      // done/err are single-cycle pulses; they are only set on the edge
      // that enters DONE.
      done <= '0;
      err  <= '0;

      case (state)
        ST_IDLE: begin
          // Never start while the writer is still finishing a transaction
          // that was orphaned by a reset.
          if (arb_valid && !wr_busy) begin
            ptr        <= IDX_W'(wrap_inc(int'(arb_idx), NUM_REQ));
            winner     <= arb_grant;
            wr_bytes   <= win_bytes;
            wr_data    <= win_data;
            sched_busy <= 1'b1;
            issue_cnt  <= '0;
            if (win_bytes == '0) begin
              state <= ST_DONE;
              done  <= arb_grant;
              err   <= arb_grant;
            end else begin
              state    <= ST_ISSUE;
              wr_ready <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          // wr_ready drops on the first edge that sees busy, well before the
          // writer can return to idle and retrigger on a stale ready.
          if (wr_busy) begin
            wr_ready <= 1'b0;
            state    <= ST_WAIT;
          end else if (issue_cnt == ISSUE_CNT_W'(ISSUE_TIMEOUT - 1)) begin
            wr_ready <= 1'b0;
            state    <= ST_DONE;
            done     <= winner;
            err      <= winner;
          end else begin
            issue_cnt <= issue_cnt + 1'b1;
          end
        end

        ST_WAIT: begin
          if (!wr_busy) begin
`ifdef DDS_IO_UPDATE_EN
            state     <= ST_UPDATE;
            io_update <= 1'b1;
            upd_cnt   <= 8'(IOUPD_CYCLES - 1);
`else
            state <= ST_DONE;
            done  <= winner;
`endif
          end
        end

`ifdef DDS_IO_UPDATE_EN
        ST_UPDATE: begin
          // io_update rose on entry; the counter holds it for IOUPD_CYCLES.
          if (upd_cnt == '0) begin
            io_update <= 1'b0;
            state     <= ST_DONE;
            done      <= winner;
          end else begin
            upd_cnt <= upd_cnt - 1'b1;
          end
        end
`endif

        ST_DONE: begin
          // No grant from this state, so the finishing requester cannot be
          // re-granted on the same edge its done pulse is visible.
          sched_busy <= 1'b0;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_spi_write_scheduler.sv
// ----------------------------------------------------------------------------
// tb_dds_spi_write_scheduler
//   Self-checking bench for dds_spi_write_scheduler with a negedge writer
//   model that shifts out wr_data MSB-first for wr_bytes*8 cycles.
//   Expected io_update behaviour follows DDS_IO_UPDATE_EN.
// ----------------------------------------------------------------------------
module tb_dds_spi_write_scheduler;

  localparam int NUM_REQ = 4;
  localparam int LBC     = 3;
  localparam int MAXLEN  = 7;
  localparam int ML8     = 56;
  localparam int IOUPD   = 4;
`ifdef DDS_IO_UPDATE_EN
  localparam int UPD_EXP = IOUPD;
`else
  localparam int UPD_EXP = 0;
`endif

  logic                   SPI_clk   = 1'b0;
  logic                   reset_n   = 1'b0;
  logic [NUM_REQ-1:0]     req       = '0;
  logic [NUM_REQ*LBC-1:0] req_bytes = '0;
  logic [NUM_REQ*ML8-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]     done;
  logic [NUM_REQ-1:0]     err;
  logic                   sched_busy;
  logic [LBC-1:0]         wr_bytes;
  logic [ML8-1:0]         wr_data;
  logic                   wr_ready;
  logic                   wr_busy   = 1'b0;
  logic                   io_update;

  int n_checks = 0;
  int n_errors = 0;

  // Writer model state.
  logic [ML8-1:0] wsh       = '0;
  logic [ML8-1:0] cap       = '0;
  int             wleft     = 0;
  int             cap_bits  = 0;
  int             starts    = 0;
  bit             writer_en = 1'b1;

  dds_spi_write_scheduler #(
    .NUM_REQ          (NUM_REQ),
    .LENGTH_BIT_COUNT (LBC),
    .MAXLENGTH        (MAXLEN),
    .MAXLENGTH8       (ML8),
    .IOUPD_CYCLES     (IOUPD)
  ) dut (
    .SPI_clk    (SPI_clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_bytes  (req_bytes),
    .req_data   (req_data),
    .done       (done),
    .err        (err),
    .sched_busy (sched_busy),
    .wr_bytes   (wr_bytes),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .wr_busy    (wr_busy),
    .io_update  (io_update)
  );

  always #5 SPI_clk = ~SPI_clk;

  // Writer: starts on a negedge that sees wr_ready while idle, then shifts
  // one bit per negedge and drops busy with the last bit.
  always @(negedge SPI_clk) begin
    if (wr_busy) begin
      cap      = {cap[ML8-2:0], wsh[ML8-1]};
      wsh      = wsh << 1;
      cap_bits = cap_bits + 1;
      wleft    = wleft - 1;
      if (wleft <= 0) wr_busy = 1'b0;
    end else if (writer_en && wr_ready && wr_bytes != '0) begin
      wr_busy  = 1'b1;
      wsh      = wr_data;
      wleft    = int'(wr_bytes) * 8;
      cap      = '0;
      cap_bits = 0;
      starts   = starts + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [LBC-1:0] nb, input logic [ML8-1:0] data);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == idx) begin
        req_bytes[i*LBC +: LBC] = nb;
        req_data[i*ML8 +: ML8]  = data;
      end
    end
  endtask

  task automatic do_reset();
    req     = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge SPI_clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Waits for a done/err pulse, counting io_update and wr_ready cycles.
  // lat = cycles from the last sample with wr_busy high to the done sample.
  // With scramble set, req is dropped and all requester inputs are trashed
  // right after the grant cycle.
  task automatic wait_done(input int budget, input bit scramble,
                           output logic [3:0] d, output logic [3:0] e,
                           output logic sb, output int upd, output int rdy,
                           output int cyc, output int lat);
    int last_busy;
    bit seen;
    d = '0; e = '0; sb = 1'b0; upd = 0; rdy = 0; cyc = 0; lat = 0;
    last_busy = 0;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge SPI_clk);
      #1;
      cyc++;
      if (io_update) upd++;
      if (wr_ready) rdy++;
      if (wr_busy) last_busy = cyc;
      if (done != '0 || err != '0) begin
        d = done; e = err; sb = sched_busy; lat = cyc - last_busy;
        seen = 1'b1;
        break;
      end
      if (scramble && c == 0) begin
        req = '0; req_bytes = '1; req_data = '1;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  typedef struct {
    int             idx;
    logic [LBC-1:0] nbytes;
    logic [ML8-1:0] data;
    logic [3:0]     exp_done;
    logic [3:0]     exp_err;
    int             exp_bits;
    logic [ML8-1:0] exp_cap;
  } vec_t;

  initial begin
    vec_t       vec [4];
    logic [3:0] d, e;
    logic       sb;
    int         upd, rdy, cyc, lat, s0, viol, n_busy;
    bit         found;

    vec[0] = '{0, 3'd3, 56'hAABBCC_00000000, 4'b0001, 4'b0000, 24, 56'hAABBCC};
    vec[1] = '{2, 3'd0, 56'h11223344556677,  4'b0100, 4'b0100, 0,  56'h0};
    vec[2] = '{1, 3'd7, 56'h0123456789ABCD,  4'b0010, 4'b0000, 56, 56'h0123456789ABCD};
    vec[3] = '{3, 3'd1, 56'hA5000000000000,  4'b1000, 4'b0000, 8,  56'hA5};

    // Reset state.
    reset_n = 1'b0;
    repeat (2) @(posedge SPI_clk);
    #1;
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy_ready_upd", 64'({sched_busy, wr_ready, io_update}), 64'd0);
    check("rst_wr_bytes", 64'(wr_bytes), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    reset_n = 1'b1;
    @(posedge SPI_clk);
    #1;

    // Table: single-requester transactions, req dropped and inputs trashed
    // after grant.
    for (int v = 0; v < 4; v++) begin
      s0 = starts;
      set_req(vec[v].idx, vec[v].nbytes, vec[v].data);
      req = 4'b0001 << vec[v].idx;
      wait_done(200, 1'b1, d, e, sb, upd, rdy, cyc, lat);
      req = '0;
      check($sformatf("v%0d_done", v), 64'(d), 64'(vec[v].exp_done));
      check($sformatf("v%0d_err", v), 64'(e), 64'(vec[v].exp_err));
      check($sformatf("v%0d_sched_busy_at_done", v), 64'(sb), 64'd1);
      check($sformatf("v%0d_io_update_cycles", v), 64'(upd),
            64'((vec[v].exp_err != '0) ? 0 : UPD_EXP));
      check($sformatf("v%0d_ready_cycles", v), 64'(rdy),
            64'((vec[v].exp_err != '0) ? 0 : 1));
      check($sformatf("v%0d_writer_starts", v), 64'(starts - s0),
            64'((vec[v].exp_err != '0) ? 0 : 1));
      if (vec[v].exp_err != '0) begin
        check($sformatf("v%0d_reject_latency", v), 64'(cyc), 64'd1);
      end else begin
        check($sformatf("v%0d_done_latency", v), 64'(lat), 64'(1 + UPD_EXP));
        check($sformatf("v%0d_shift_bits", v), 64'(cap_bits), 64'(vec[v].exp_bits));
        check($sformatf("v%0d_shift_data", v), 64'(cap), 64'(vec[v].exp_cap));
      end
      @(posedge SPI_clk);
      #1;
      check($sformatf("v%0d_pulse_one_cycle", v), 64'({done, err}), 64'd0);
      check($sformatf("v%0d_sched_busy_clear", v), 64'(sched_busy), 64'd0);
      req_bytes = '0;
      req_data  = '0;
    end

    // All requesters held: strict rotation from pointer 0.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 3'd1, {8'h10 + 8'(i), 48'h0});
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      s0 = starts;
      wait_done(100, 1'b0, d, e, sb, upd, rdy, cyc, lat);
      if (k == 4) req = '0;
      check($sformatf("rr%0d_done", k), 64'(d), 64'(4'b0001 << (k % 4)));
      check($sformatf("rr%0d_err", k), 64'(e), 64'd0);
      check($sformatf("rr%0d_data", k), 64'(cap), 64'(8'h10 + 8'(k % 4)));
      check($sformatf("rr%0d_single_start", k), 64'(starts - s0), 64'd1);
    end
    @(posedge SPI_clk);
    #1;

    // Reset while WAIT: no done for the old winner, no grant until the
    // orphaned write ends, pointer back at 0.
    do_reset();
    set_req(2, 3'd7, 56'hFEDCBA98765432);
    req   = 4'b0100;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge SPI_clk);
      #1;
      if (wr_busy && !wr_ready && sched_busy) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_mid_reached_wait", 64'(found), 64'd1);
    repeat (3) @(posedge SPI_clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_async_clear", 64'({sched_busy, wr_ready, done, err, io_update}), 64'd0);
    req = '0;
    repeat (2) @(posedge SPI_clk);
    #1;
    set_req(1, 3'd1, 56'h3C000000000000);
    set_req(3, 3'd1, 56'hC3000000000000);
    req     = 4'b1010;
    reset_n = 1'b1;
    viol    = 0;
    n_busy  = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge SPI_clk);
      #1;
      if (!wr_busy) break;
      n_busy++;
      if (done != '0 || err != '0 || wr_ready || sched_busy) viol++;
    end
    check("rst_mid_writer_still_busy", 64'(n_busy > 0), 64'd1);
    check("rst_mid_no_activity_while_busy", 64'(viol), 64'd0);
    check("rst_mid_writer_finished", 64'(wr_busy), 64'd0);
    wait_done(100, 1'b0, d, e, sb, upd, rdy, cyc, lat);
    req = 4'b1000;
    check("rst_mid_ptr_restart_done", 64'(d), 64'b0010);
    check("rst_mid_ptr_restart_err", 64'(e), 64'd0);
    wait_done(100, 1'b0, d, e, sb, upd, rdy, cyc, lat);
    req = '0;
    check("rst_mid_second_done", 64'(d), 64'b1000);
    check("rst_mid_second_data", 64'(cap), 64'hC3);

    // Writer stall: ready held 8 cycles, then done+err.
    do_reset();
    writer_en = 1'b0;
    set_req(0, 3'd2, 56'h12340000000000);
    req = 4'b0001;
    wait_done(40, 1'b0, d, e, sb, upd, rdy, cyc, lat);
    req = '0;
    check("stall_done", 64'(d), 64'b0001);
    check("stall_err", 64'(e), 64'b0001);
    check("stall_ready_cycles", 64'(rdy), 64'd8);
    check("stall_done_cycle", 64'(cyc), 64'd9);
    check("stall_no_io_update", 64'(upd), 64'd0);
    @(posedge SPI_clk);
    #1;
    check("stall_idle_after", 64'({done, err, sched_busy, wr_ready}), 64'd0);
    writer_en = 1'b1;
    req = 4'b0001;
    wait_done(100, 1'b0, d, e, sb, upd, rdy, cyc, lat);
    req = '0;
    check("stall_recover_done", 64'(d), 64'b0001);
    check("stall_recover_err", 64'(e), 64'd0);
    check("stall_recover_data", 64'(cap), 64'h1234);
    @(posedge SPI_clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
